tree_divider: RTL and testbench

Sequential unsigned divider that inverts the `AdderTree` multiplier. It accepts a 2·2**N-bit product-width dividend and a 2**N-bit divisor, and returns a 2·2**N-bit quotient and a 2**N-bit remainder. It uses a restoring shift-subtract datapath that resolves one quotient bit per clock. It sits beside `AdderTree` in the arithmetic block so that a product `P` can be divided by one operand to recover the other, with valid/ready handshakes on both sides.

---
 rtl/tree_divider.sv | 129 ++++++++++++
 tb/tb_tree_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tree_divider.sv
// tree_divider: sequential restoring divider that recovers one factor of an
// AdderTree product. A 2W-bit dividend is divided by a W-bit divisor, and one
// quotient bit is resolved per clock. There is a valid/ready handshake on the
// input side and on the output side.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | in_ready high, waiting for a dividend/divisor pair
// RUN   | one shift-subtract step per cycle, 2W steps in total
// DONE  | result presented with out_valid, held until out_ready
module tree_divider #(
    parameter int N = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*(2**N)-1:0]     P,
    input  logic [(2**N)-1:0]       B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*(2**N)-1:0]     Q,
    output logic [(2**N)-1:0]       R,
    output logic                    dbz
);

    localparam int W  = 2**N;
    localparam int DW = 2*W;
    // One spare bit so the counter can never wrap before the terminal compare.
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    // The dividend shifts out at the top while quotient bits shift in at the
    // bottom. After 2W steps the register holds only the quotient.
    logic [DW-1:0]   dvd_q;
    logic [W-1:0]    div_b;
    logic [W-1:0]    rem;
    logic [CW-1:0]   cnt;
    logic            dbz_pend;
    logic [W-1:0]    p_lo;

    logic [W:0]      rem_sh;
    logic            ge;
    logic [W-1:0]    rem_nx;
    logic [DW-1:0]   dvd_q_nx;

    // One restoring step: bring in the next dividend bit, then subtract the
    // divisor if it fits. If the subtract is skipped, rem_sh is below the
    // divisor, so its top bit is zero and can be dropped.
    always_comb begin
        rem_sh   = {rem, dvd_q[DW-1]};
        ge       = (rem_sh >= {1'b0, div_b});
        rem_nx   = ge ? W'(rem_sh - {1'b0, div_b}) : rem_sh[W-1:0];
        dvd_q_nx = {dvd_q[DW-2:0], ge};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dvd_q     <= '0;
            div_b     <= '0;
            rem       <= '0;
            cnt       <= '0;
            dbz_pend  <= 1'b0;
            p_lo      <= '0;
            Q         <= '0;
            R         <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q    <= P;
                        div_b    <= B;
                        rem      <= '0;
                        cnt      <= '0;
                        dbz_pend <= (B == '0);
                        p_lo     <= P[W-1:0];
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    dvd_q <= dvd_q_nx;
                    rem   <= rem_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        // A zero divisor still runs all 2W steps, so latency
                        // is the same; the result is replaced only at the end.
                        if (dbz_pend) begin
                            Q   <= '1;
                            R   <= p_lo;
                            dbz <= 1'b1;
                        end else begin
                            Q   <= dvd_q_nx;
                            R   <= rem_nx;
                            dbz <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_divider.sv
// Directed bench for tree_divider at N=3 (8-bit divisor, 16-bit dividend).
module tb_tree_divider;

    localparam int N  = 3;
    localparam int W  = 2**N;
    localparam int DW = 2*W;
    localparam int LAT = DW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] P;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Q;
    logic [W-1:0]  R;
    logic          dbz;

    int checks = 0;
    int errors = 0;

    tree_divider #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .P(P), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .R(R), .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] p;
        logic [W-1:0]  b;
        logic [DW-1:0] q;
        logic [W-1:0]  r;
        logic          z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a pair, scramble the inputs during RUN, then wait for out_valid
    // and return the number of edges counted after the accept edge.
    task automatic start_and_wait(input logic [DW-1:0] p, input logic [W-1:0] b,
                                  output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin tick(); guard++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        P = p;
        B = b;
        tick();
        in_valid = 1'b0;
        P = ~p;
        B = b + 8'd3;
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_rise", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [DW-1:0] hq;
        logic [W-1:0]  hr;

        vecs[0]  = '{16'd120,   8'd10,  16'd12,    8'd0,   1'b0};
        vecs[1]  = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0};
        vecs[2]  = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0};
        vecs[3]  = '{16'd257,   8'd2,   16'd128,   8'd1,   1'b0};
        vecs[4]  = '{16'd254,   8'd127, 16'd2,     8'd0,   1'b0};
        vecs[5]  = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};
        vecs[6]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
        // AdderTree product 12*10 = 120, divided by A = 12 gives back 10.
        vecs[7]  = '{16'd120,   8'd12,  16'd10,    8'd0,   1'b0};
        vecs[8]  = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0};
        vecs[9]  = '{16'hFFFF,  8'hFF,  16'h0101,  8'd0,   1'b0};
        vecs[10] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0};
        vecs[11] = '{16'hABCD,  8'h10,  16'h0ABC,  8'h0D,  1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        P = '0;
        B = '0;
        #23;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);

        for (int i = 0; i < 12; i++) begin
            start_and_wait(vecs[i].p, vecs[i].b, lat);
            check($sformatf("lat[%0d]", i), 32'(lat), 32'(LAT));
            check($sformatf("Q[%0d]", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("R[%0d]", i), 32'(R), 32'(vecs[i].r));
            check($sformatf("dbz[%0d]", i), 32'(dbz), 32'(vecs[i].z));
            handshake();
            tick();
            check($sformatf("Q_hold_idle[%0d]", i), 32'(Q), 32'(vecs[i].q));
        end

        // Back-pressure with in_valid held high behind the current pair.
        start_and_wait(16'd1000, 8'd7, lat);
        in_valid = 1'b1;
        P = 16'd120;
        B = 8'd10;
        check("bp_lat", 32'(lat), 32'(LAT));
        hq = 16'd142;
        hr = 8'd6;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_Q", 32'(Q), 32'(hq));
            check("bp_R", 32'(R), 32'(hr));
        end
        handshake();
        tick();
        check("bp_reaccept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        check("bp2_lat", 32'(lat), 32'(LAT));
        check("bp2_Q", 32'(Q), 32'd12);
        check("bp2_R", 32'(R), 32'd0);
        handshake();

        // Reset in the middle of RUN aborts the pair.
        tick();
        in_valid = 1'b1;
        P = 16'd1000;
        B = 8'd7;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_Q", 32'(Q), 32'd0);
        check("abort_R", 32'(R), 32'd0);
        check("abort_dbz", 32'(dbz), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_in_ready_rel", 32'(in_ready), 32'd1);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 25; c++) begin
                tick();
                if (out_valid) seen++;
            end
            check("abort_no_result", 32'(seen), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
